serial_eq_compare_ctrl: RTL and testbench
=========================================

# serial_eq_compare_ctrl

Sequencing controller that compares two WIDTH-bit operands for equality using a single shared 4-bit equality comparator, one nibble per clock, LSB nibble first. It stops at the first mismatching nibble and reports the result with a one-cycle done pulse. It sits between a requester with a valid/ready start interface and the 4-bit xnor/and equality datapath, so wide comparisons reuse one small comparator.

## Interface
- WIDTH, default 16: operand width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, derived as WIDTH/4: number of compare steps.
- IDX_W, derived as max(1, $clog2(NIBBLES)): width of the nibble index.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  requester presents operands a/b.
- start_ready  out  1  controller can accept; high only in IDLE.
- a  in  WIDTH  first operand; sampled on accept.
- b  in  WIDTH  second operand; sampled on accept.
- abort  in  1  synchronous cancel; honoured only in COMPARE.
- busy  out  1  high in COMPARE and DONE.
- done  out  1  one-cycle result pulse.
- equal  out  1  result; 1 means a == b.
- mismatch_idx  out  IDX_W  index of the first differing nibble; 0 when equal.

## Operation
- Accept: a transfer occurs on an edge where start_valid && start_ready. On that edge a and b are captured into internal registers, idx is set to 0, and the FSM enters COMPARE.
- IDLE: start_ready=1 and busy=0. abort is ignored.
- COMPARE: the comparator is driven with a_reg[4*idx+:4] and b_reg[4*idx+:4]. The compare result (eq) is combinational within the same cycle. At the clock edge, actions apply in this priority order:
  - abort=1: go to IDLE. No done pulse. equal and mismatch_idx keep their previous values.
  - eq=0: set equal to 0, set mismatch_idx to idx, go to DONE.
  - eq=1 and idx==NIBBLES-1: set equal to 1, set mismatch_idx to 0, go to DONE.
  - Otherwise: increment idx and stay in COMPARE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally. start_valid is not accepted in DONE.
- equal and mismatch_idx are registered. They change only on the transition into DONE and hold their value until the next result.
- Operands are held in internal registers, so a and b may change freely after the accept edge.
- idx never wraps: the counter saturates at NIBBLES-1 because the FSM leaves COMPARE at that point.

## Timing
- Reset values: FSM=IDLE, idx=0, start_ready=1, busy=0, done=0, equal=0, mismatch_idx=0. Operand registers reset to 0.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous). No done pulse is produced.
- Latency: with the accept at edge E0 and the first mismatch at nibble k (or k=NIBBLES-1 on a full match), done is high in the cycle after edge E(k+1). That is k+1 cycles after accept.
- The earliest next accept is the edge following the done cycle, so the full period is k+3 edges.
- If start_valid is held high continuously, requests are accepted back-to-back, once per completion.
- abort and a mismatch in the same cycle: abort wins.

## Structure
- A shared package serial_eq_pkg holds:
  - the state enum {IDLE, COMPARE, DONE};
  - a NIBBLE_W=4 constant;
  - a function computing IDX_W from WIDTH.
- One sub-module, nibble_eq4: a 4-bit equality unit built from four xnor gates and one 4-input and gate. It is instantiated once and is purely combinational.
- The controller owns the FSM, the idx counter, the operand registers, the nibble mux and the result registers.

## Test plan
- Full match, a=b=16'hBEEF: accept at E0 gives done=1 in the cycle after E4 with equal=1 and mismatch_idx=0. busy stays high throughout.
- Early mismatch, a=16'h1234, b=16'h1235: done in the cycle after E1, equal=0, mismatch_idx=0.
- Top-nibble mismatch, a=16'hA000, b=16'hB000: done after E4, equal=0, mismatch_idx=3.
- Abort on the second COMPARE cycle after a completed 16'h1234/16'h1235 result: no done pulse, start_ready=1 on the next cycle, equal stays 0 and mismatch_idx stays 0.
- rst_n pulsed low mid-COMPARE: all outputs go to reset values immediately. A new accept after rst_n is released compares correctly.
- start_valid held high with new operands each accept: one done per request, no accepts during COMPARE or DONE, and the per-request latency matches the rule in Timing.

Source files
------------

// File: rtl/serial_eq_compare_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_eq_pkg
// Description : Shared types and constants for the serial nibble-wise
//               equality compare controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_eq_pkg;

  // Width of one compare step (one nibble).
  localparam int NIBBLE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Width of the nibble index for a given operand width; never below 1 bit.
  function automatic int calc_idx_w(input int width);
    int nibbles;
    nibbles = width / NIBBLE_W;
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_eq_compare_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_eq_compare_ctrl_if
// Description : Requester-side start handshake, abort and result bundle.
//               master = requester, slave = compare controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_eq_compare_ctrl_if
  import serial_eq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = calc_idx_w(WIDTH)
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             equal;
  logic [IDX_W-1:0] mismatch_idx;

  modport master (
    output start_valid, a, b, abort,
    input  start_ready, busy, done, equal, mismatch_idx
  );

  modport slave (
    input  start_valid, a, b, abort,
    output start_ready, busy, done, equal, mismatch_idx
  );
endinterface
`default_nettype wire

// File: rtl/serial_eq_compare_ctrl_nibble_eq4.sv
`default_nettype none
// ============================================================================
// Module      : nibble_eq4
// Description : 4-bit equality unit: four xnor gates feeding a 4-input and.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_eq4 (
  input  wire logic [3:0] a_i,
  input  wire logic [3:0] b_i,
  output logic            eq_o
);
  logic [3:0] w_bit_eq;

  // One xnor per bit position.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign w_bit_eq[i] = ~(a_i[i] ^ b_i[i]);
  end

  assign eq_o = &w_bit_eq;
endmodule
`default_nettype wire

// File: rtl/serial_eq_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_eq_compare_ctrl
// Description : Compares two WIDTH-bit operands one nibble per clock (LSB
//               nibble first) through a single shared 4-bit comparator, stops
//               at the first differing nibble and pulses done with the result.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_eq_compare_ctrl
  import serial_eq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  serial_eq_compare_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = calc_idx_w(WIDTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             equal_q, equal_d;
  logic [IDX_W-1:0] mism_q, mism_d;
  logic             w_load;
  logic             w_eq;

  logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];

  // Split the captured operands into nibbles for the step mux.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
    assign w_a_nib[i] = a_q[i*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib[i] = b_q[i*NIBBLE_W +: NIBBLE_W];
  end

  nibble_eq4 u_eq (
    .a_i  (w_a_nib[idx_q]),
    .b_i  (w_b_nib[idx_q]),
    .eq_o (w_eq)
  );

  // Next-state, index and result decisions; abort has top priority in COMPARE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    equal_d = equal_q;
    mism_d  = mism_q;
    w_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          w_load  = 1'b1;
          idx_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!w_eq) begin
          equal_d = 1'b0;
          mism_d  = idx_q;
          state_d = DONE;
        end else if (idx_q == C_LAST_IDX) begin
          equal_d = 1'b1;
          mism_d  = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, nibble index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      equal_q <= 1'b0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      equal_q <= equal_d;
      mism_q  <= mism_d;
    end
  end

  // Operand capture on accept so the requester may change a/b afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (w_load) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.equal        = equal_q;
  assign bus.mismatch_idx = mism_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_eq_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_eq_compare_ctrl
// Description : Self-checking bench for serial_eq_compare_ctrl with a
//               nibble-scan reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_eq_compare_ctrl;
  import serial_eq_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_eq_compare_ctrl_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  serial_eq_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic             exp_equal = 1'b0;
  logic [IDX_W-1:0] exp_idx   = '0;

  // Index of the lowest differing nibble, or -1 when the operands are equal.
  function automatic int first_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = 0; i < NIBBLES; i++) begin
      if (((a >> (4*i)) & 16'hF) != ((b >> (4*i)) & 16'hF)) return i;
    end
    return -1;
  endfunction

  // One request; entered and left on a falling edge. hold keeps start_valid high.
  task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    int k, lat, n;
    k   = first_diff(a, b);
    lat = (k < 0) ? NIBBLES : k + 1;
    checks++;
    if (bus.start_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: got %b want 1", bus.start_ready);
    end
    bus.a = a; bus.b = b; bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
        errors++; $display("FAIL busy_during: busy=%b ready=%b want 1/0 at cycle %0d", bus.busy, bus.start_ready, n);
      end
      @(negedge clk);
      n++;
    end
    exp_equal = (k < 0);
    exp_idx   = (k < 0) ? '0 : IDX_W'(k);
    checks++;
    if (n != lat) begin
      errors++; $display("FAIL latency a=%h b=%h: got %0d want %0d", a, b, n, lat);
    end
    checks++;
    if (bus.equal !== exp_equal || bus.busy !== 1'b1) begin
      errors++; $display("FAIL equal a=%h b=%h: got %b busy=%b want %b busy=1", a, b, bus.equal, bus.busy, exp_equal);
    end
    checks++;
    if (bus.mismatch_idx !== exp_idx) begin
      errors++; $display("FAIL mismatch_idx a=%h b=%h: got %0d want %0d", a, b, bus.mismatch_idx, exp_idx);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL after_done: done=%b ready=%b busy=%b want 0/1/0", bus.done, bus.start_ready, bus.busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.equal !== exp_equal || bus.mismatch_idx !== exp_idx) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b done=%b equal=%b idx=%0d want 1/0/0/%b/%0d",
               tag, bus.start_ready, bus.busy, bus.done, bus.equal, bus.mismatch_idx, exp_equal, exp_idx);
    end
  endtask

  task automatic test_reset();
    exp_equal = 1'b0; exp_idx = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_asserted");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_directed();
    run_one(16'hBEEF, 16'hBEEF, 1'b0);
    run_one(16'h1234, 16'h1235, 1'b0);
    run_one(16'hA000, 16'hB000, 1'b0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    int k;
    logic [31:0] upper;
    for (int it = 0; it < 24; it++) begin
      a = WIDTH'($urandom);
      k = $urandom_range(0, NIBBLES);
      if (k == NIBBLES) begin
        b = a;
      end else begin
        upper = $urandom & (32'hFFFF_FFFF << (4*(k+1)));
        b = a ^ WIDTH'((32'($urandom_range(1, 15)) << (4*k)) | upper);
      end
      run_one(a, b, 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] v;
    run_one(16'h1234, 16'h1235, 1'b0);
    v = WIDTH'($urandom);
    bus.a = v; bus.b = v; bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle_outputs("abort_idle");
    @(negedge clk);
    check_idle_outputs("abort_no_done");
    run_one(16'h00F0, 16'h00F0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_one(16'h0F00, 16'h0000, 1'b0);
    bus.a = 16'h5555; bus.b = 16'h5555; bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_equal = 1'b0; exp_idx = '0;
    check_idle_outputs("reset_mid_async");
    @(negedge clk);
    check_idle_outputs("reset_mid_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_one(16'hC3A5, 16'hC3A5, 1'b0);
    run_one(16'h7000, 16'h6000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a;
    for (int it = 0; it < 6; it++) begin
      a = WIDTH'($urandom);
      if (it % 3 == 0) run_one(a, a, 1'b1);
      else run_one(a, a ^ WIDTH'(32'h1 << (4*$urandom_range(0, NIBBLES-1))), 1'b1);
    end
    bus.start_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
